// File: rtl/shift_sequencer_pkg.sv
// Shared ALU shift definitions: op encodings, sequencer state encodings, default widths.
package shift_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_AMT_W = 4;

   localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
   localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
   localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
   localparam logic [1:0] SHIFT_OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_sequencer_step.sv
// One-bit shift stage. Rotate-left on op=11 exists only with SHIFT_SEQ_ROTATE_EN;
// otherwise op=11 behaves as SLL.
module shift_step
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] value,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      shifted = {value[WIDTH-2:0], 1'b0};
      case (op)
         SHIFT_OP_SRL: shifted = {1'b0, value[WIDTH-1:1]};
         SHIFT_OP_SRA: shifted = {value[WIDTH-1], value[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
         SHIFT_OP_ROL: shifted = {value[WIDTH-2:0], value[WIDTH-1]};
`endif
         default:      shifted = {value[WIDTH-2:0], 1'b0};
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: applies one shift_step per clock, amount times.
// Optional rotate-left on op=11 is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int AMT_W = DEFAULT_AMT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] operand,
   input  logic [AMT_W-1:0] amount,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       state
);

   // Handshake: start is a request qualified by !busy; a start seen while busy
   // is dropped, not queued. done pulses for one cycle with result valid, and
   // result holds until the next accepted request completes.

   state_t           state_q;
   logic [WIDTH-1:0] acc;
   logic [AMT_W-1:0] cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] step_out;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .value   (acc),
      .op      (op_q),
      .shifted (step_out)
   );

   assign state = state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         acc     <= '0;
         cnt     <= '0;
         op_q    <= SHIFT_OP_SLL;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  acc  <= operand;
                  cnt  <= amount;
                  op_q <= op;
                  busy <= 1'b1;
                  // A zero-length shift skips SHIFT and completes next cycle.
                  if (amount == '0) begin
                     state_q <= ST_DONE;
                     done    <= 1'b1;
                     result  <= operand;
                  end else begin
                     state_q <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               acc <= step_out;
               cnt <= cnt - AMT_W'(1);
               if (cnt == AMT_W'(1)) begin
                  state_q <= ST_DONE;
                  done    <= 1'b1;
                  result  <= step_out;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
